// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator sharing one prescaler and one counter.
//
// Ports:
//   clk           sole clock, all state changes on its rising edge
//   rst           synchronous active-high reset
//   enable        1 = run; 0 = hold counter at zero, outputs low, reload settings
//   mode          0 = edge-aligned, 1 = center-aligned (latched at period boundary)
//   prescale      counter advances every prescale+1 clocks
//   period        counter top value (latched at period boundary)
//   wr_en         duty write strobe
//   wr_chan       channel index for the write (out-of-range indices are ignored)
//   wr_duty       duty value to write into the channel's shadow register
//   pwm_out       registered PWM outputs, one per channel
//   period_start  one-clock pulse in the clock where the counter sits at zero
//                 after a period boundary
module pwm_bank #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRE_W    = 8,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mode,
  input  logic [PRE_W-1:0]    prescale,
  input  logic [WIDTH-1:0]    period,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [CW:0]      CH_LIM = (CW + 1)'(CHANNELS);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [PRE_W-1:0]    pre_cnt_reg;
  logic [PRE_W-1:0]    pre_cnt_next;
  logic [WIDTH-1:0]    cnt_reg;
  logic [WIDTH-1:0]    cnt_next;
  logic                dir_reg;       // 0 = counting up, 1 = counting down
  logic                dir_next;
  logic [WIDTH-1:0]    period_act_reg;
  logic                mode_act_reg;
  logic [WIDTH-1:0]    shadow_reg [CHANNELS];
  logic [WIDTH-1:0]    active_reg [CHANNELS];
  logic [CHANNELS-1:0] pwm_reg;
  logic [CHANNELS-1:0] pwm_next;
  logic                period_start_reg;
  logic                tick;
  logic                boundary;
  logic                going_down;
  logic                wr_ok;

  assign pwm_out      = pwm_reg;
  assign period_start = period_start_reg;
  assign wr_ok        = wr_en && ({1'b0, wr_chan} < CH_LIM);

  // '>=' rather than '==' so a prescale lowered below the running count
  // still produces a tick instead of wrapping through the full range.
  assign tick         = (pre_cnt_reg >= prescale);
  assign pre_cnt_next = tick ? '0 : pre_cnt_reg + 1'b1;

  // Center mode turns around at the top in the same tick that reaches it;
  // the '>=' also pulls a stale count back inside the period.
  assign going_down   = dir_reg || (cnt_reg >= period_act_reg);

  always_comb begin
    cnt_next = cnt_reg;
    dir_next = dir_reg;
    boundary = 1'b0;
    if (tick) begin
      if (period_act_reg == '0) begin
        cnt_next = '0;
        dir_next = 1'b0;
        boundary = 1'b1;
      end else if (!mode_act_reg) begin
        if (cnt_reg >= period_act_reg) begin
          cnt_next = '0;
          boundary = 1'b1;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end else if (going_down) begin
        // Reaching zero on the way down ends the period; the counter then
        // heads straight back up without dwelling at zero.
        if (cnt_reg <= ONE) begin
          cnt_next = '0;
          dir_next = 1'b0;
          boundary = 1'b1;
        end else begin
          cnt_next = cnt_reg - ONE;
          dir_next = 1'b1;
        end
      end else begin
        cnt_next = cnt_reg + ONE;
      end
    end
  end

  // Per-channel compare against the counter value before this edge.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
      assign pwm_next[gi] = (cnt_reg < active_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_reg      <= '0;
      cnt_reg          <= '0;
      dir_reg          <= 1'b0;
      period_act_reg   <= '0;
      mode_act_reg     <= 1'b0;
      pwm_reg          <= '0;
      period_start_reg <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      // Shadow writes are accepted whether or not the bank is running.
      // Active registers below sample the pre-write shadow contents.
      if (wr_ok) begin
        shadow_reg[wr_chan] <= wr_duty;
      end

      if (!enable) begin
        pre_cnt_reg      <= '0;
        cnt_reg          <= '0;
        dir_reg          <= 1'b0;
        pwm_reg          <= '0;
        period_start_reg <= 1'b0;
        period_act_reg   <= period;
        mode_act_reg     <= mode;
        for (int i = 0; i < CHANNELS; i++) begin
          active_reg[i] <= shadow_reg[i];
        end
      end else begin
        pre_cnt_reg      <= pre_cnt_next;
        cnt_reg          <= cnt_next;
        dir_reg          <= dir_next;
        pwm_reg          <= pwm_next;
        period_start_reg <= boundary;
        if (boundary) begin
          period_act_reg <= period;
          mode_act_reg   <= mode;
          for (int i = 0; i < CHANNELS; i++) begin
            active_reg[i] <= shadow_reg[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed self-checking bench for pwm_bank (3 channels, 8-bit).
module tb_pwm_bank;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          mode;
  logic [PW-1:0] prescale;
  logic [W-1:0]  period;
  logic          wr_en;
  logic [1:0]    wr_chan;
  logic [W-1:0]  wr_duty;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  int checks   = 0;
  int failures = 0;

  pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .prescale     (prescale),
    .period       (period),
    .wr_en        (wr_en),
    .wr_chan      (wr_chan),
    .wr_duty      (wr_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_duty(input logic [1:0] ch, input logic [W-1:0] v);
    wr_en   = 1'b1;
    wr_chan = ch;
    wr_duty = v;
    step();
    wr_en   = 1'b0;
  endtask

  // Leaves the bank disabled with settings and active duties loaded.
  task automatic setup(input logic m, input logic [PW-1:0] pre, input logic [W-1:0] per,
                       input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
    enable   = 1'b0;
    rst      = 1'b0;
    mode     = m;
    prescale = pre;
    period   = per;
    write_duty(2'd0, d0);
    write_duty(2'd1, d1);
    write_duty(2'd2, d2);
    step();
    step();
  endtask

  task automatic test_reset();
    int c [CH];
    rst = 1'b1; enable = 1'b1; mode = 1'b0; prescale = '0; period = 8'd9;
    wr_en = 1'b1; wr_chan = 2'd0; wr_duty = 8'd55;
    step();
    step();
    checks++;
    if (pwm_out !== 3'b000) begin
      failures++;
      $display("FAIL reset_pwm got=%b want=000", pwm_out);
    end
    checks++;
    if (period_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_ps got=%b want=0", period_start);
    end
    rst = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < CH; i++) c[i] = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      for (int i = 0; i < CH; i++) c[i] += int'(pwm_out[i]);
    end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (c[i] !== 0) begin
        failures++;
        $display("FAIL reset_duty_ch%0d high=%0d want=0", i, c[i]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_edge();
    int c0 = 0, c1 = 0, c2 = 0, ps_n = 0, first_ps = -1, last_ps = -1;
    setup(1'b0, 8'd0, 8'd99, 8'd25, 8'd50, 8'd0);
    enable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      c2 += int'(pwm_out[2]);
      if (period_start) begin
        ps_n++;
        if (first_ps < 0) first_ps = k;
        last_ps = k;
      end
    end
    checks++;
    if (c0 !== 50) begin failures++; $display("FAIL edge_ch0_high got=%0d want=50", c0); end
    checks++;
    if (c1 !== 100) begin failures++; $display("FAIL edge_ch1_high got=%0d want=100", c1); end
    checks++;
    if (c2 !== 0) begin failures++; $display("FAIL edge_ch2_high got=%0d want=0", c2); end
    checks++;
    if (ps_n !== 2) begin failures++; $display("FAIL edge_ps_count got=%0d want=2", ps_n); end
    checks++;
    if (first_ps !== 99) begin failures++; $display("FAIL edge_ps_first got=%0d want=99", first_ps); end
    checks++;
    if (last_ps !== 199) begin failures++; $display("FAIL edge_ps_last got=%0d want=199", last_ps); end
    $display("test_edge done c0=%0d c1=%0d c2=%0d ps=%0d", c0, c1, c2, ps_n);
  endtask

  task automatic test_full_duty();
    int c0 = 0, c1 = 0, c2 = 0, ps_n = 0;
    setup(1'b0, 8'd0, 8'd99, 8'd100, 8'd255, 8'd0);
    enable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      c2 += int'(pwm_out[2]);
      ps_n += int'(period_start);
    end
    checks++;
    if (c0 !== 300) begin failures++; $display("FAIL full_duty100 got=%0d want=300", c0); end
    checks++;
    if (c1 !== 300) begin failures++; $display("FAIL full_duty255 got=%0d want=300", c1); end
    checks++;
    if (c2 !== 0) begin failures++; $display("FAIL full_duty0 got=%0d want=0", c2); end
    checks++;
    if (ps_n !== 3) begin failures++; $display("FAIL full_ps_count got=%0d want=3", ps_n); end
    $display("test_full_duty done");
  endtask

  task automatic test_back_to_back();
    int p [4];
    int want [4];
    int c0 = 0, ps_n = 0;
    want[0] = 50; want[1] = 70; want[2] = 70; want[3] = 10;
    for (int i = 0; i < 4; i++) p[i] = 0;
    setup(1'b0, 8'd0, 8'd99, 8'd25, 8'd50, 8'd0);
    enable = 1'b1;
    for (int k = 0; k < 400; k++) begin
      step();
      p[k / 100] += int'(pwm_out[1]);
      c0 += int'(pwm_out[0]);
      ps_n += int'(period_start);
      // Mid-period write, then a write landing on the boundary tick (edge 199).
      if (k == 30)  begin wr_en = 1'b1; wr_chan = 2'd1; wr_duty = 8'd70; end
      if (k == 198) begin wr_en = 1'b1; wr_chan = 2'd1; wr_duty = 8'd10; end
      if (k == 31 || k == 199) wr_en = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (p[i] !== want[i]) begin
        failures++;
        $display("FAIL update_ch1_period%0d high=%0d want=%0d", i, p[i], want[i]);
      end
    end
    checks++;
    if (c0 !== 100) begin failures++; $display("FAIL update_ch0 high=%0d want=100", c0); end
    checks++;
    if (ps_n !== 4) begin failures++; $display("FAIL update_ps_count got=%0d want=4", ps_n); end
    $display("test_back_to_back done %0d/%0d/%0d/%0d", p[0], p[1], p[2], p[3]);
  endtask

  task automatic test_center();
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;
    int            m;
    setup(1'b1, 8'd0, 8'd4, 8'd2, 8'd5, 8'd1);
    enable = 1'b1;
    // Counter 0,1,2,3,4,3,2,1 repeating; sample k reflects count at position k%8.
    for (int k = 0; k < 24; k++) begin
      step();
      m = k % 8;
      exp_pwm[0] = (m == 0 || m == 1 || m == 7);
      exp_pwm[1] = 1'b1;
      exp_pwm[2] = (m == 0);
      exp_ps     = (m == 7);
      checks++;
      if (pwm_out !== exp_pwm) begin
        failures++;
        $display("FAIL center_pwm k=%0d got=%b want=%b", k, pwm_out, exp_pwm);
      end
      checks++;
      if (period_start !== exp_ps) begin
        failures++;
        $display("FAIL center_ps k=%0d got=%b want=%b", k, period_start, exp_ps);
      end
    end
    $display("test_center done");
  endtask

  task automatic test_period_zero();
    setup(1'b0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (pwm_out !== 3'b001 || period_start !== 1'b1) begin
        failures++;
        $display("FAIL pzero k=%0d got pwm=%b ps=%b want pwm=001 ps=1", k, pwm_out, period_start);
      end
    end
    $display("test_period_zero done");
  endtask

  task automatic test_prescale_rst();
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;
    setup(1'b0, 8'd3, 8'd9, 8'd5, 8'd0, 8'd10);
    enable = 1'b1;
    // Count advances every 4 clocks: count at sample k = (k/4) % 10.
    for (int k = 0; k < 91; k++) begin
      step();
      exp_pwm[0] = ((k % 40) < 20);
      exp_pwm[1] = 1'b0;
      exp_pwm[2] = 1'b1;
      exp_ps     = ((k % 40) == 39);
      checks++;
      if (pwm_out !== exp_pwm || period_start !== exp_ps) begin
        failures++;
        $display("FAIL prescale k=%0d got pwm=%b ps=%b want pwm=%b ps=%b",
                 k, pwm_out, period_start, exp_pwm, exp_ps);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (pwm_out !== 3'b000 || period_start !== 1'b0) begin
      failures++;
      $display("FAIL midrst got pwm=%b ps=%b want pwm=000 ps=0", pwm_out, period_start);
    end
    enable = 1'b0;
    step();
    rst = 1'b0;
    $display("test_prescale_rst done");
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 1'b0; prescale = '0; period = '0;
    wr_en = 1'b0; wr_chan = '0; wr_duty = '0;
    step();
    test_reset();
    test_edge();
    test_full_duty();
    test_back_to_back();
    test_center();
    test_period_zero();
    test_prescale_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent PWM outputs (1..16).
REQ-002 Parameter WIDTH, default 8: width of counter, period and duty values.
REQ-003 Parameter PRE_W, default 8: width of prescaler compare value.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port enable  input  1  1 = run; 0 = hold counters at zero, outputs low.
REQ-007 Port mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-008 Port prescale  input  PRE_W  tick every prescale+1 clocks.
REQ-009 Port period  input  WIDTH  counter top value.
REQ-010 Port wr_en  input  1  duty write strobe.
REQ-011 Port wr_chan  input  max(1,$clog2(CHANNELS))  channel index for write.
REQ-012 Port wr_duty  input  WIDTH  duty value to write.
REQ-013 Port pwm_out  output  CHANNELS  registered PWM outputs.
REQ-014 Port period_start  output  1  one-clock pulse at each PWM period boundary.

Function
REQ-015 Prescaler pre_cnt SHALL count 0..prescale; tick=1 in the clock where pre_cnt==prescale, pre_cnt then returns to 0; prescale=0 gives tick every clock.
REQ-016 Edge mode: on tick, cnt SHALL increment, wrapping from period_act to 0; PWM period = (period_act+1) ticks.
REQ-017 Center mode: on tick, cnt SHALL count up 0..period_act, then down to 0, then up again; direction reverses at the ends without dwelling; PWM period = 2*period_act ticks.
REQ-018 period_act==0 (either mode): cnt SHALL stay 0 and every tick SHALL be a boundary.
REQ-019 Boundary SHALL be the tick that moves cnt to 0 (edge: from period_act; center: from 1 while counting down).
REQ-020 At a boundary, active_duty[i] SHALL load shadow_duty[i] for all channels, and period_act and mode_act SHALL load period and mode, all in the same clock.
REQ-021 period_start SHALL be 1 for exactly the clock after the boundary tick (coincident with cnt==0); otherwise 0.
REQ-022 wr_en=1 with wr_chan<CHANNELS SHALL update shadow_duty[wr_chan] on the next edge; wr_chan>=CHANNELS SHALL be ignored.
REQ-023 A write in the same clock as a boundary SHALL NOT reach active_duty in that boundary; active loads the pre-write shadow value, and the new value applies at the following boundary.
REQ-024 pwm_out[i] SHALL be registered as enable & (cnt < active_duty[i]) using the current cnt, i.e. one clock behind cnt.
REQ-025 active_duty=0 SHALL give constant low; active_duty > period_act SHALL give constant high (edge mode) with no glitch at wrap.
REQ-026 Comparison SHALL be unsigned, WIDTH bits; cnt SHALL never exceed period_act.
REQ-027 enable=0 SHALL force pre_cnt=0, cnt=0, direction=up, pwm_out=0, period_start=0, and load active/period_act/mode_act from inputs every clock; shadow writes remain accepted.
REQ-028 On enable 0->1, counting SHALL start from cnt=0 with the values held in REQ-027; the first period_start follows the first boundary.

Reset
REQ-029 rst=1 SHALL on the next edge clear pre_cnt, cnt, direction (up), all shadow and active duties, period_act, mode_act, pwm_out and period_start to 0; rst has priority over enable and wr_en.
REQ-030 rst asserted mid-period SHALL take effect on the next edge regardless of tick or direction state.

Verification
REQ-031 rst high 2 clocks with wr_en=1 -> pwm_out=0, period_start=0, all duties read back 0 after release.
REQ-032 CHANNELS=3, WIDTH=8, edge mode, prescale=0, period=99, duties 25/50/0 -> per 100 clocks pwm_out[0] high 25, [1] high 50, [2] never; period_start every 100 clocks.
REQ-033 period=99, duty 100 and duty 255 -> constant high across 3 periods; duty 0 -> constant low.
REQ-034 Write ch1=70 mid-period -> output unchanged until the next period_start; write coincident with boundary -> takes effect one period later.
REQ-035 Center mode, period=4, duty=2, prescale=0 -> cnt 0,1,2,3,4,3,2,1 repeating; pwm_out high 3 of 8 clocks, symmetric; period_start every 8 clocks.
REQ-036 prescale=3, period=9 -> cnt advances every 4 clocks, period_start every 40 clocks; rst mid-period -> cnt=0, pwm_out=0 next clock.
